// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - quadrature state constants, direction codes and up-sequence helper
package quad_pkg;

    localparam logic [1:0] Q00 = 2'b00;
    localparam logic [1:0] Q10 = 2'b10;
    localparam logic [1:0] Q11 = 2'b11;
    localparam logic [1:0] Q01 = 2'b01;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Successor of a {a,b} state when moving up: 00 -> 10 -> 11 -> 01 -> 00
    function automatic logic [1:0] next_up(input logic [1:0] state);
        logic [1:0] nxt;
        case (state)
            Q00:     nxt = Q10;
            Q10:     nxt = Q11;
            Q11:     nxt = Q01;
            default: nxt = Q00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// rtl/quad_glitch_filter.sv - two-flop synchronizer plus consecutive-sample glitch filter for one channel
module quad_glitch_filter
    import quad_pkg::*;
#(
    parameter int FILT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic stable
);

    localparam logic [3:0] FILT_M1 = 4'(FILT - 1);

    logic       s1;
    logic       s2;
    logic       filt;
    logic [3:0] cnt;
    // s1 holds a real sample only from the second edge after reset; until then
    // the cleared synchronizer must not be mistaken for a settled input.
    logic       primed;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            filt   <= 1'b0;
            cnt    <= 4'd0;
            primed <= 1'b0;
        end else begin
            s1     <= din;
            s2     <= s1;
            primed <= 1'b1;
            if (s2 != filt) begin
                if (cnt == FILT_M1) begin
                    filt <= s2;
                    cnt  <= 4'd0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end else begin
                cnt <= 4'd0;
            end
        end
    end

    assign dout   = filt;
    // Nothing in flight anywhere between the pin and filt
    assign stable = primed && (s1 == s2) && (s2 == filt) && (cnt == 4'd0);

endmodule

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature decoder producing ce/dir steps, illegal-transition err and a wrapping position
module quad_decoder
    import quad_pkg::*;
#(
    parameter int N    = 3,
    parameter int FILT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_in,
    input  logic         b_in,
    input  logic         clr,
    output logic         ce,
    output logic         dir,
    output logic         err,
    output logic [N-1:0] pos
);

    localparam logic [N-1:0] POS_ONE = {{(N-1){1'b0}}, 1'b1};

    logic       filt_a;
    logic       filt_b;
    logic       stable_a;
    logic       stable_b;
    logic       armed;
    logic [1:0] prev;
    logic [1:0] cur;

    quad_glitch_filter #(.FILT(FILT)) u_filt_a (
        .clk    (clk),
        .rst    (rst),
        .din    (a_in),
        .dout   (filt_a),
        .stable (stable_a)
    );

    quad_glitch_filter #(.FILT(FILT)) u_filt_b (
        .clk    (clk),
        .rst    (rst),
        .din    (b_in),
        .dout   (filt_b),
        .stable (stable_b)
    );

    assign cur = {filt_a, filt_b};

    always_ff @(posedge clk) begin
        if (rst) begin
            armed <= 1'b0;
            prev  <= Q00;
            ce    <= 1'b0;
            dir   <= DIR_UP;
            err   <= 1'b0;
            pos   <= '0;
        end else begin
            ce   <= 1'b0;
            err  <= 1'b0;
            // prev always follows the filtered state so arming starts from
            // whatever the encoder is actually sitting at.
            prev <= cur;
            if (!armed) begin
                armed <= stable_a && stable_b;
            end else if (cur != prev) begin
                if (cur == next_up(prev)) begin
                    ce  <= 1'b1;
                    dir <= DIR_UP;
                    pos <= pos + POS_ONE;
                end else if (prev == next_up(cur)) begin
                    ce  <= 1'b1;
                    dir <= DIR_DN;
                    pos <= pos - POS_ONE;
                end else begin
                    err <= 1'b1;
                end
            end
            if (clr) begin
                pos <= '0;
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - table-driven and directed self-checking bench for quad_decoder
module tb_quad_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_in;
    logic       b_in;
    logic       clr;
    logic       ce;
    logic       dir;
    logic       err;
    logic [2:0] pos;

    int n_chk  = 0;
    int n_fail = 0;

    int   ce_cnt  = 0;
    int   err_cnt = 0;
    int   ce_wide = 0;
    logic ce_q    = 1'b0;
    logic ce_dirs[$];

    typedef struct {
        logic       a;
        logic       b;
        int         ce_d;
        int         err_d;
        logic       dir;
        logic [2:0] pos;
    } vec_t;

    vec_t vecs[14];

    quad_decoder #(.N(3), .FILT(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .a_in (a_in),
        .b_in (b_in),
        .clr  (clr),
        .ce   (ce),
        .dir  (dir),
        .err  (err),
        .pos  (pos)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            ce_q <= 1'b0;
        end else begin
            if (ce) begin
                ce_cnt <= ce_cnt + 1;
                ce_dirs.push_back(dir);
            end
            if (err) err_cnt <= err_cnt + 1;
            if (ce && ce_q) ce_wide <= ce_wide + 1;
            ce_q <= ce;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic a, input logic b, input int hold);
        @(posedge clk);
        #1;
        a_in = a;
        b_in = b;
        repeat (hold) @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] tb_up(input logic [1:0] s);
        logic [1:0] r;
        if (s == 2'b00)      r = 2'b10;
        else if (s == 2'b10) r = 2'b11;
        else if (s == 2'b11) r = 2'b01;
        else                 r = 2'b00;
        return r;
    endfunction

    initial begin
        int         c0;
        int         e0;
        logic [1:0] st;
        logic [2:0] exp_pos;

        // State after the hand-written first up step: {a,b}=10, pos=1, dir=1
        vecs[0]  = '{1'b1, 1'b1, 1, 0, 1'b1, 3'd2};
        vecs[1]  = '{1'b0, 1'b1, 1, 0, 1'b1, 3'd3};
        vecs[2]  = '{1'b0, 1'b0, 1, 0, 1'b1, 3'd4};
        vecs[3]  = '{1'b0, 1'b1, 1, 0, 1'b0, 3'd3};
        vecs[4]  = '{1'b1, 1'b1, 1, 0, 1'b0, 3'd2};
        vecs[5]  = '{1'b1, 1'b0, 1, 0, 1'b0, 3'd1};
        vecs[6]  = '{1'b0, 1'b0, 1, 0, 1'b0, 3'd0};
        vecs[7]  = '{1'b0, 1'b1, 1, 0, 1'b0, 3'd7};
        vecs[8]  = '{1'b1, 1'b1, 1, 0, 1'b0, 3'd6};
        vecs[9]  = '{1'b0, 1'b0, 0, 1, 1'b0, 3'd6};
        vecs[10] = '{1'b1, 1'b0, 1, 0, 1'b1, 3'd7};
        vecs[11] = '{1'b1, 1'b1, 1, 0, 1'b1, 3'd0};
        vecs[12] = '{1'b0, 1'b1, 1, 0, 1'b1, 3'd1};
        vecs[13] = '{1'b0, 1'b0, 1, 0, 1'b1, 3'd2};

        rst  = 1'b1;
        a_in = 1'b0;
        b_in = 1'b0;
        clr  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ce", int'(ce), 0);
        chk("reset_dir", int'(dir), 1);
        chk("reset_err", int'(err), 0);
        chk("reset_pos", int'(pos), 0);
        rst = 1'b0;
        repeat (6) @(posedge clk);

        // First up step with exact latency: ce visible only after the 4th edge past sampling
        @(posedge clk);
        #1;
        a_in = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("lat_ce_early", int'(ce), 0);
        @(negedge clk);
        chk("lat_ce", int'(ce), 1);
        chk("lat_pos", int'(pos), 1);
        chk("lat_dir", int'(dir), 1);
        @(negedge clk);
        chk("lat_ce_width", int'(ce), 0);
        repeat (5) @(posedge clk);

        for (int i = 0; i < 14; i++) begin
            c0 = ce_cnt;
            e0 = err_cnt;
            step(vecs[i].a, vecs[i].b, 10);
            chk($sformatf("vec%0d_ce", i), ce_cnt - c0, vecs[i].ce_d);
            chk($sformatf("vec%0d_err", i), err_cnt - e0, vecs[i].err_d);
            chk($sformatf("vec%0d_dir", i), int'(dir), int'(vecs[i].dir));
            chk($sformatf("vec%0d_pos", i), int'(pos), int'(vecs[i].pos));
        end

        // Glitch rejection from state 00, pos=2
        c0 = ce_cnt;
        @(posedge clk);
        #1;
        a_in = 1'b1;
        @(posedge clk);
        #1;
        a_in = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("glitch1_ce", ce_cnt - c0, 0);
        chk("glitch1_pos", int'(pos), 2);

        ce_dirs.delete();
        c0 = ce_cnt;
        @(posedge clk);
        #1;
        a_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        a_in = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("glitch3_ce", ce_cnt - c0, 2);
        chk("glitch3_dir0", (ce_dirs.size() > 0) ? int'(ce_dirs[0]) : -1, 1);
        chk("glitch3_dir1", (ce_dirs.size() > 1) ? int'(ce_dirs[1]) : -1, 0);
        chk("glitch3_pos", int'(pos), 2);

        // clr on the same edge that raises ce: clr wins on pos, ce/dir still pulse
        @(posedge clk);
        #1;
        a_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        chk("clr_ce", int'(ce), 1);
        chk("clr_dir", int'(dir), 1);
        chk("clr_pos", int'(pos), 0);
        repeat (6) @(posedge clk);
        #1;
        chk("clr_pos_hold", int'(pos), 0);

        // Eight up steps from pos=0 wrap back to 0
        st      = 2'b10;
        exp_pos = 3'd0;
        c0      = ce_cnt;
        for (int i = 0; i < 8; i++) begin
            st      = tb_up(st);
            exp_pos = exp_pos + 3'd1;
            step(st[1], st[0], 10);
            chk($sformatf("wrap%0d_pos", i), int'(pos), int'(exp_pos));
        end
        chk("wrap_ce_total", ce_cnt - c0, 8);

        // Reset mid-motion with 11 held through release
        @(posedge clk);
        #1;
        a_in = 1'b1;
        b_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mid_ce", int'(ce), 0);
        chk("rst_mid_dir", int'(dir), 1);
        chk("rst_mid_err", int'(err), 0);
        chk("rst_mid_pos", int'(pos), 0);
        rst = 1'b0;
        c0  = ce_cnt;
        e0  = err_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_idle_ce", ce_cnt - c0, 0);
        chk("rst_idle_err", err_cnt - e0, 0);
        chk("rst_idle_pos", int'(pos), 0);
        c0 = ce_cnt;
        e0 = err_cnt;
        step(1'b0, 1'b1, 10);
        chk("rst_next_ce", ce_cnt - c0, 1);
        chk("rst_next_err", err_cnt - e0, 0);
        chk("rst_next_dir", int'(dir), 1);
        chk("rst_next_pos", int'(pos), 1);

        chk("ce_single_cycle", ce_wide, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
